pipelined_cla_addsub: RTL
=========================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational group-CLA adder.
- Operand width, lookahead group size and pipeline depth are configurable. Add or subtract is selected per operation.
- The carry chain is split across STAGES registered slices with a valid/ready handshake and full backpressure.
- Sits between the ALU operand mux and the writeback path in the datapath.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of STAGES*GROUP.
- GROUP, 4, bits per lookahead group (generate/propagate per group, second-level lookahead across the groups of a slice).
- STAGES, 2, pipeline stages (1..8). Each stage resolves SLICE = WIDTH/STAGES bits.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation present on a, b, sub
- in_ready  output  1  pipeline can accept operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A-B, 0 = A+B
- out_valid  output  1  result fields valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 one cycle after rst_n rises; it is also 1 during reset since the pipe is empty.
- Reset mid-operation discards all in-flight operations. There is no partial output.
- Operand conditioning at accept: b_eff = sub ? ~b : b; carry-in c0 = sub.
- Stage k (k=0..STAGES-1) computes slice bits [(k+1)*SLICE-1 : k*SLICE]:
  - Inputs are a, b_eff and the carry registered by stage k-1 (c0 for stage 0).
  - Within a slice: per-bit g=a&b, p=a^b; per-group G/P; group carries by lookahead from the slice carry-in; s = p ^ carry.
  - No ripple between groups inside a slice.
- Each stage register holds: valid bit, sum bits already resolved, unresolved upper a/b_eff bits, slice carry-out, and the sign bits needed for ovf.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance when out_ready is held 1.
- Throughput: 1 op/cycle.
- Final stage outputs:
  - sum = all slices.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum==0).
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Stage k loads when !valid_k | ready_{k+1}; the ready of the last stage is out_ready. in_ready = ready_0 (combinational from out_ready through the stage valids).
  - A stalled stage holds all its fields unchanged.
  - out_valid, sum and flags stay stable until accepted.
- Simultaneous accept and emit in the same cycle with a full pipe: permitted, no bubble.
- Full pipe with out_ready=0: in_ready=0, and no input is accepted or lost.
- Empty pipe: out_valid=0 and output fields hold their last value (not checked).
- Wrap-around: sum is modulo 2^WIDTH; overflow is signalled only via cout/ovf.
- STAGES=1 degenerates to a single-register CLA with latency 1.

Test Plan:
- Reset, then add: rst_n pulse; a=32'h0000_0001, b=32'hFFFF_FFFF, sub=0 -> after 2 cycles out_valid=1, sum=0, cout=1, ovf=0, zero=1.
- Signed overflow: a=32'h7FFF_FFFF, b=1, sub=0 -> sum=32'h8000_0000, cout=0, ovf=1. Sub case: a=32'h8000_0000, b=1, sub=1 -> sum=32'h7FFF_FFFF, ovf=1, cout=1.
- Cross-slice carry: a=32'h0000_FFFF, b=1 -> sum=32'h0001_0000; the carry propagates from stage 0 into stage 1 with no latency change. Subtract 5-7 -> sum=32'hFFFF_FFFE, cout=0.
- Back-to-back streaming of 100 random ops with out_ready=1 -> one result per cycle, in order, each matching the reference model, latency 2.
- Backpressure: fill the pipe, drop out_ready for 5 cycles -> in_ready=0 after 2 accepts, outputs stable; on release, results drain in order with none lost or duplicated.
- Asynchronous reset asserted with 2 ops in flight -> out_valid=0 immediately; after release, no stale result emerges. Repeat the random test with STAGES=1, 4 and WIDTH=64.

Source files
------------

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for pipelined_cla_addsub.
//   master: the producer/consumer side (drives in_valid, a, b, sub, out_ready)
//   slave : the adder pipeline (drives in_ready, out_valid, sum, cout, ovf, zero)
// Signals: in_valid/in_ready accept an operation on a, b, sub (1 = a-b);
//          out_valid/out_ready transfer sum plus cout, ovf and zero flags.
interface pipelined_cla_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Each of STAGES registered slices resolves SLICE = WIDTH/STAGES bits with a
// two-level lookahead (per-group G/P, then group carries from the slice
// carry-in). Valid/ready handshake with full backpressure, 1 op/cycle,
// latency STAGES.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes all in-flight operations
//   bus   : slave side of pipelined_cla_addsub_if (operands in, result out)
module pipelined_cla_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned GROUP  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipelined_cla_addsub_if.slave  bus
);
   localparam int unsigned SLICE = WIDTH / STAGES;
   localparam int unsigned NGRP  = SLICE / GROUP;

   // rdy[k] : stage k may load; rdy[STAGES] is the downstream ready
   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] vin, cin, nx_c;
   logic [STAGES-1:0] v_q, c_q;
   logic [WIDTH-1:0]  op_a [STAGES];
   logic [WIDTH-1:0]  op_b [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [WIDTH-1:0]  nx_s [STAGES];
   logic [WIDTH-1:0]  nx_a [STAGES];
   logic [WIDTH-1:0]  nx_b [STAGES];
   logic [WIDTH-1:0]  s_q  [STAGES];
   logic [WIDTH-1:0]  a_q  [STAGES];
   logic [WIDTH-1:0]  b_q  [STAGES];
   logic              nx_ovf, nx_zero, ovf_q, zero_q;

   assign rdy[STAGES]  = bus.out_ready;
   assign bus.in_ready = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SLICE-1:0] sa, sb, g, p, s;
      logic [SLICE:0]   c;
      logic [NGRP-1:0]  gg, pg;
      logic [NGRP:0]    cg;

      assign rdy[k] = ~v_q[k] | rdy[k+1];

      if (k == 0) begin : g_first
         assign vin[k]  = bus.in_valid;
         assign op_a[k] = bus.a;
         assign op_b[k] = bus.sub ? ~bus.b : bus.b;
         assign cin[k]  = bus.sub;
         assign s_in[k] = '0;
      end else begin : g_next
         assign vin[k]  = v_q[k-1];
         assign op_a[k] = a_q[k-1];
         assign op_b[k] = b_q[k-1];
         assign cin[k]  = c_q[k-1];
         assign s_in[k] = s_q[k-1];
      end

      // Unresolved operand bits are kept shifted down so every stage works
      // on bits [SLICE-1:0] of its operand word.
      assign sa = op_a[k][SLICE-1:0];
      assign sb = op_b[k][SLICE-1:0];

      always_comb begin
         logic t;
         t  = 1'b0;
         g  = sa & sb;
         p  = sa ^ sb;
         gg = '0;
         pg = '1;
         cg = '0;
         c  = '0;
         for (int unsigned j = 0; j < NGRP; j++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
               gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
               pg[j] = pg[j] & p[j*GROUP+i];
            end
         end
         // Group carries: sum-of-products straight from the slice carry-in,
         // no carry passed from one group to the next.
         cg[0] = cin[k];
         for (int unsigned j = 1; j <= NGRP; j++) begin
            t = cin[k];
            for (int unsigned n = 0; n < j; n++) t = t & pg[n];
            cg[j] = t;
            for (int unsigned m = 0; m < j; m++) begin
               t = gg[m];
               for (int unsigned n = m + 1; n < j; n++) t = t & pg[n];
               cg[j] = cg[j] | t;
            end
         end
         // Bit carries inside each group, lookahead from the group carry-in.
         for (int unsigned j = 0; j < NGRP; j++) begin
            c[j*GROUP] = cg[j];
            for (int unsigned i = 1; i < GROUP; i++) begin
               t = cg[j];
               for (int unsigned n = 0; n < i; n++) t = t & p[j*GROUP+n];
               c[j*GROUP+i] = t;
               for (int unsigned m = 0; m < i; m++) begin
                  t = g[j*GROUP+m];
                  for (int unsigned n = m + 1; n < i; n++) t = t & p[j*GROUP+n];
                  c[j*GROUP+i] = c[j*GROUP+i] | t;
               end
            end
         end
         c[SLICE] = cg[NGRP];
         s = p ^ c[SLICE-1:0];
      end

      assign nx_s[k] = s_in[k] | (WIDTH'(s) << (k * SLICE));
      assign nx_c[k] = c[SLICE];

      if (k < STAGES - 1) begin : g_pass
         assign nx_a[k] = op_a[k] >> SLICE;
         assign nx_b[k] = op_b[k] >> SLICE;
      end else begin : g_last
         assign nx_a[k] = '0;
         assign nx_b[k] = '0;
         // Carry into the MSB is the slice's top internal carry.
         assign nx_ovf  = c[SLICE-1] ^ c[SLICE];
         assign nx_zero = (nx_s[k] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            s_q[k] <= '0;
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v_q[k] <= vin[k];
               if (vin[k]) begin
                  s_q[k] <= nx_s[k];
                  c_q[k] <= nx_c[k];
                  a_q[k] <= nx_a[k];
                  b_q[k] <= nx_b[k];
               end
            end
         end
         if (rdy[STAGES-1] && vin[STAGES-1]) begin
            ovf_q  <= nx_ovf;
            zero_q <= nx_zero;
         end
      end
   end

   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
